// File: rtl/fetch_unit.sv
// fetch_unit: program counter and sequencer for the 8-bit datapath.
// Holds the PC and the ALU flag register, and resolves jumps and flag-conditional
// branches through a small writable target table.
// Implements the start/halt/done handshake with the harness.
module fetch_unit #(
    parameter int PC_W      = 10,
    parameter int LUT_DEPTH = 16
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            start,
    input  logic            halt,
    input  logic            flag_in,
    input  logic            flag_we,
    input  logic            branch_en,
    input  logic            jump_en,
    input  logic [3:0]      target_idx,
    input  logic            lut_we,
    input  logic [3:0]      lut_waddr,
    input  logic [PC_W-1:0] lut_wdata,
    output logic [PC_W-1:0] pc,
    output logic            flag_q,
    output logic            running,
    output logic            done,
    output logic [15:0]     cycle_count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              flag_d;
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic [15:0]       cycle_count_q, cycle_count_d;
    logic [PC_W-1:0]   lut_q [LUT_DEPTH];
    logic [PC_W-1:0]   lut_d [LUT_DEPTH];

    assign pc          = pc_q;
    assign running     = running_q;
    assign done        = done_q;
    assign cycle_count = cycle_count_q;

    // Next-state logic: table write, FSM transitions, PC selection, flag and cycle counter
    always_comb begin
        lut_d         = lut_q;
        state_d       = state_q;
        pc_d          = pc_q;
        flag_d        = flag_q;
        cycle_count_d = cycle_count_q;

        // Table writes happen in every state; reads below use lut_q, so a
        // same-cycle read of the written index returns the old entry.
        if (lut_we)
            lut_d[lut_waddr] = lut_wdata;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d       = RUN;
                    pc_d          = '0;
                    cycle_count_d = '0;
                    flag_d        = 1'b0;
                end
            end
            RUN: begin
                if (cycle_count_q != 16'hFFFF)
                    cycle_count_d = cycle_count_q + 16'd1;
                // The flag is captured at the edge; a branch in this cycle
                // still sees the pre-edge flag_q.
                if (flag_we)
                    flag_d = flag_in;
                if (halt)
                    state_d = DONE;
                else if (jump_en)
                    pc_d = lut_q[target_idx];
                else if (branch_en && flag_q)
                    pc_d = lut_q[target_idx];
                else
                    pc_d = pc_q + PC_W'(1);
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are registered copies of the next state.
        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    // State registers; reset clears everything including the target table
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            flag_q        <= 1'b0;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
            cycle_count_q <= '0;
            for (int i = 0; i < LUT_DEPTH; i++)
                lut_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            flag_q        <= flag_d;
            running_q     <= running_d;
            done_q        <= done_d;
            cycle_count_q <= cycle_count_d;
            lut_q         <= lut_d;
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and sequencing stage that drives instruction fetch for the 8-bit datapath and consumes the ALU's `flag` output. It holds the PC, latches the ALU flag into a flag register, resolves unconditional jumps and flag-conditional branches through a small writable target lookup table, and implements the start/halt/done handshake with the test harness. It sits directly downstream of the ALU (flag) and upstream of instruction memory (PC).

## Interface
Parameters:
- `PC_W`, 10: PC and target width in bits.
- `LUT_DEPTH`, 16: number of branch/jump target entries; index width is 4 bits.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin program execution at PC 0.
- `halt`  in  1  stop execution; decoded from the current instruction.
- `flag_in`  in  1  ALU `flag` output.
- `flag_we`  in  1  capture `flag_in` into `flag_q`.
- `branch_en`  in  1  take the branch to `lut[target_idx]` if `flag_q` is 1.
- `jump_en`  in  1  unconditional jump to `lut[target_idx]`.
- `target_idx`  in  4  target table index.
- `lut_we`  in  1  write to the target table.
- `lut_waddr`  in  4  target table write index.
- `lut_wdata`  in  PC_W  target table write data.
- `pc`  out  PC_W  current instruction address.
- `flag_q`  out  1  registered flag.
- `running`  out  1  high in state RUN.
- `done`  out  1  high in state DONE.
- `cycle_count`  out  16  number of RUN cycles since the last accepted start; saturates at the maximum.

## Operation
- States are IDLE, RUN and DONE. Reset puts the block in IDLE.
- Reset values: `pc`=0, `flag_q`=0, `running`=0, `done`=0, `cycle_count`=0. All table entries are 0.
- IDLE:
  - `start`=1 → RUN, `pc`←0, `cycle_count`←0, `flag_q`←0.
  - All other inputs except the table write port are ignored.
- RUN: next-PC priority, highest first:
  1. `halt` → `pc` holds, go to DONE.
  2. `jump_en` → `pc`←`lut[target_idx]`.
  3. `branch_en` with `flag_q`=1 → `pc`←`lut[target_idx]`.
  4. Otherwise → `pc`←`pc`+1, modulo 2^PC_W. 2^PC_W−1 wraps to 0 with no error.
- `branch_en` with `flag_q`=0 increments the PC normally.
- Flag register:
  - `flag_we`=1 in RUN → `flag_q`←`flag_in` at the edge.
  - A branch evaluated in the same cycle uses the pre-edge `flag_q`, not `flag_in`.
  - `flag_we` is ignored in IDLE and DONE.
- `cycle_count` increments on every edge taken in RUN, including the halting edge. It saturates at 0xFFFF.
- DONE:
  - `pc`, `flag_q` and `cycle_count` hold.
  - `start`=1 restarts exactly as from IDLE.
  - `done` stays high until a start is accepted.
- Target table:
  - `lut_we` writes `lut[lut_waddr]`←`lut_wdata` at the edge, in any state.
  - A same-cycle read of the same index returns the old entry.
- Reset takes priority over everything, including a mid-RUN reset and a simultaneous `start`. It clears the table.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Start latency:
  - `start` sampled at edge N → `running`=1 and `pc`=0 after edge N.
  - The first increment happens at edge N+1.
- Halt latency:
  - `halt` sampled at edge N → `done`=1 and `running`=0 after edge N.
  - `pc` equals its pre-edge value.
- Jump/branch: the target is visible on `pc` one cycle after it is sampled. No delay slot.
- `start` is level-sampled and not edge-detected. Holding `start` high in DONE restarts the program every cycle in which the block re-enters DONE.

## Test plan
- Reset, then `start` pulse, then 5 idle RUN cycles → `pc` sequence 0,1,2,3,4,5. `running`=1. `cycle_count`=5.
- Load `lut[3]`=0x2A. In RUN at `pc`=7:
  - `flag_we`=1 with `flag_in`=1, next cycle `branch_en`=1, `target_idx`=3 → `pc`=0x2A.
  - Repeat with `flag_in`=0 → `pc`=9.
- Same cycle `flag_we`=1, `flag_in`=1, `branch_en`=1 with `flag_q`=0 → not taken, `pc`+1. Next cycle `flag_q`=1.
- `jump_en`=1 and `halt`=1 together at `pc`=0x10 → DONE, `pc`=0x10, `done`=1. Then `start` → `pc`=0, `done`=0, `cycle_count`=0.
- With PC_W=10, jump to `lut` entry 0x3FF and run one cycle → `pc`=0. With `cycle_count` forced near its limit by a long run → holds at 0xFFFF.
- Assert `Reset` mid-RUN at `pc`=0x55 with `lut[1]`=0x12 → next cycle all outputs 0, IDLE. Afterwards `jump_en`, `target_idx`=1 after start → `pc`=0 because the table was cleared.
